// File: rtl/fetch_decode_pkg.sv
// Shared constants for the fetch/decode block: opcode and funct3 encodings,
// the controller state type, the fetch timeout length and decode helpers.
package fetch_decode_pkg;

  localparam logic [6:0] OP_ADDI   = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [2:0] F3_ADDI   = 3'b000;
  localparam logic [2:0] F3_BNE    = 3'b001;

  localparam int TIMEOUT_CYCLES = 16;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } state_t;

  function automatic logic is_addi(input logic [31:0] instr);
    return (instr[6:0] == OP_ADDI) && (instr[14:12] == F3_ADDI);
  endfunction

  function automatic logic is_bne(input logic [31:0] instr);
    return (instr[6:0] == OP_BRANCH) && (instr[14:12] == F3_BNE);
  endfunction

endpackage

// File: rtl/fetch_decode_imm_gen.sv
// Immediate extraction for the fetch/decode block. Takes the two instruction
// slices that carry immediate bits (IR[31:20] and IR[11:7]) and produces the
// sign-extended I-type operand and the sign-extended B-type branch offset.
module imm_gen
  import fetch_decode_pkg::*;
#(
  parameter int PC_WIDTH  = 32,
  parameter int IMM_WIDTH = 12
) (
  input  logic [11:0]          ir_hi,
  input  logic [4:0]           ir_lo,
  output logic [IMM_WIDTH-1:0] imm_i,
  output logic [PC_WIDTH-1:0]  imm_b
);

  logic [12:0] b_raw;

  // Reassemble the scattered branch offset; bit 0 is always zero
  always_comb begin
    b_raw = {ir_hi[11], ir_lo[0], ir_hi[10:5], ir_lo[4:1], 1'b0};
  end

  assign imm_i = IMM_WIDTH'($signed(ir_hi));
  assign imm_b = PC_WIDTH'($signed(b_raw));

endmodule

// File: rtl/fetch_decode.sv
// Minimal fetch/decode controller supporting addi and bne.
// FETCH requests an instruction word, EXEC decodes it for one cycle and
// updates the PC, HALT is entered on an illegal opcode and left only by reset.
// Optional feature: define FETCH_DECODE_TIMEOUT_EN to halt after a fetch
// waits TIMEOUT_CYCLES consecutive cycles without an acknowledge.
module fetch_decode
  import fetch_decode_pkg::*;
#(
  parameter int                  PC_WIDTH  = 32,
  parameter int                  ADD_WIDTH = 5,
  parameter int                  IMM_WIDTH = 12,
  parameter logic [PC_WIDTH-1:0] RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 imem_req,
  output logic [PC_WIDTH-1:0]  imem_addr,
  input  logic                 imem_ack,
  input  logic [31:0]          imem_rdata,
  input  logic                 EQ,
  output logic [ADD_WIDTH-1:0] rs1,
  output logic [ADD_WIDTH-1:0] rs2,
  output logic [ADD_WIDTH-1:0] rd,
  output logic                 RegWrite,
  output logic [IMM_WIDTH-1:0] ImmOp,
  output logic                 ALUsrc,
  output logic                 ALUctrl,
  output logic [PC_WIDTH-1:0]  pc,
  output logic                 illegal,
  output logic                 imem_timeout
);

  state_t               state;
  logic [31:0]          ir;
  logic [IMM_WIDTH-1:0] imm_i;
  logic [PC_WIDTH-1:0]  imm_b;
  logic                 dec_addi;
  logic                 dec_bne;

  logic [ADD_WIDTH-1:0] rs1_q;
  logic [ADD_WIDTH-1:0] rs2_q;
  logic [ADD_WIDTH-1:0] rd_q;
  logic [IMM_WIDTH-1:0] imm_q;
  logic                 alusrc_q;
  logic                 aluctrl_q;

`ifdef FETCH_DECODE_TIMEOUT_EN
  localparam logic [4:0] TO_LAST = 5'(TIMEOUT_CYCLES - 1);
  logic [4:0] to_cnt;
`else
  assign imem_timeout = 1'b0;
`endif

  assign imem_addr = pc;
  assign dec_addi  = is_addi(ir);
  assign dec_bne   = is_bne(ir);

  imm_gen #(
    .PC_WIDTH (PC_WIDTH),
    .IMM_WIDTH(IMM_WIDTH)
  ) u_imm_gen (
    .ir_hi(ir[31:20]),
    .ir_lo(ir[11:7]),
    .imm_i(imm_i),
    .imm_b(imm_b)
  );

  // Decode outputs follow the IR during EXEC and show the held copy otherwise
  always_comb begin
    rs1      = rs1_q;
    rs2      = rs2_q;
    rd       = rd_q;
    ImmOp    = imm_q;
    ALUsrc   = alusrc_q;
    ALUctrl  = aluctrl_q;
    RegWrite = 1'b0;
    if (state == EXEC && dec_addi) begin
      rd       = ADD_WIDTH'(ir[11:7]);
      rs1      = ADD_WIDTH'(ir[19:15]);
      ImmOp    = imm_i;
      ALUsrc   = 1'b1;
      ALUctrl  = 1'b0;
      RegWrite = 1'b1;
    end else if (state == EXEC && dec_bne) begin
      rs1     = ADD_WIDTH'(ir[19:15]);
      rs2     = ADD_WIDTH'(ir[24:20]);
      ALUsrc  = 1'b0;
      ALUctrl = 1'b1;
    end
  end

  // Remember the decoded values so they hold steady outside EXEC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      imm_q     <= '0;
      alusrc_q  <= 1'b0;
      aluctrl_q <= 1'b0;
    end else if (state == EXEC) begin
      rs1_q     <= rs1;
      rs2_q     <= rs2;
      rd_q      <= rd;
      imm_q     <= ImmOp;
      alusrc_q  <= ALUsrc;
      aluctrl_q <= ALUctrl;
    end
  end

  // Controller: fetch handshake, PC update, illegal/timeout halting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FETCH;
      pc       <= RESET_PC;
      ir       <= '0;
      imem_req <= 1'b0;
      illegal  <= 1'b0;
`ifdef FETCH_DECODE_TIMEOUT_EN
      to_cnt       <= '0;
      imem_timeout <= 1'b0;
`endif
    end else begin
      case (state)
        FETCH: begin
          if (!imem_req) begin
            imem_req <= 1'b1;
          end else if (imem_ack) begin
            ir       <= imem_rdata;
            imem_req <= 1'b0;
            state    <= EXEC;
`ifdef FETCH_DECODE_TIMEOUT_EN
            to_cnt   <= '0;
`endif
          end
`ifdef FETCH_DECODE_TIMEOUT_EN
          else if (to_cnt == TO_LAST) begin
            imem_req     <= 1'b0;
            imem_timeout <= 1'b1;
            to_cnt       <= '0;
            state        <= HALT;
          end else begin
            to_cnt <= to_cnt + 5'd1;
          end
`endif
        end
        EXEC: begin
          if (dec_addi) begin
            pc       <= pc + PC_WIDTH'(4);
            imem_req <= 1'b1;
            state    <= FETCH;
          end else if (dec_bne) begin
            pc       <= EQ ? (pc + PC_WIDTH'(4)) : (pc + imm_b);
            imem_req <= 1'b1;
            state    <= FETCH;
          end else begin
            illegal  <= 1'b1;
            imem_req <= 1'b0;
            state    <= HALT;
          end
        end
        HALT: begin
          imem_req <= 1'b0;
        end
        default: begin
          imem_req <= 1'b0;
          state    <= HALT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_decode.sv
// Directed testbench for fetch_decode: reset values, addi decode, bne taken
// and not taken, delayed acknowledge, illegal opcode halt, reset during a
// pending fetch, and fetch timeout behaviour (FETCH_DECODE_TIMEOUT_EN).
module tb_fetch_decode;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        EQ;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic        RegWrite;
  logic [11:0] ImmOp;
  logic        ALUsrc;
  logic        ALUctrl;
  logic [31:0] pc;
  logic        illegal;
  logic        imem_timeout;

  int total = 0;
  int bad   = 0;

  fetch_decode #(
    .PC_WIDTH (32),
    .ADD_WIDTH(5),
    .IMM_WIDTH(12),
    .RESET_PC (32'h0)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .EQ          (EQ),
    .rs1         (rs1),
    .rs2         (rs2),
    .rd          (rd),
    .RegWrite    (RegWrite),
    .ImmOp       (ImmOp),
    .ALUsrc      (ALUsrc),
    .ALUctrl     (ALUctrl),
    .pc          (pc),
    .illegal     (illegal),
    .imem_timeout(imem_timeout)
  );

  // 10-unit clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something never returns
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Wait for a request, hold off the ack for dly cycles, then deliver word.
  // Returns on the falling edge inside the EXEC cycle.
  task automatic applyStimulus(input logic [31:0] word, input int dly, input logic [31:0] expAddr);
    int n = 0;
    while (!imem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("req_seen", {31'b0, imem_req}, 32'd1);
    for (int i = 0; i < dly; i++) begin
      checkOutput("wait_req", {31'b0, imem_req}, 32'd1);
      checkOutput("wait_addr", imem_addr, expAddr);
      checkOutput("wait_regwrite", {31'b0, RegWrite}, 32'd0);
      @(negedge clk);
    end
    checkOutput("ack_req", {31'b0, imem_req}, 32'd1);
    checkOutput("ack_addr", imem_addr, expAddr);
    imem_ack   = 1'b1;
    imem_rdata = word;
    @(negedge clk);
    imem_ack = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    EQ         = 1'b0;

    @(negedge clk);
    checkOutput("rst_req", {31'b0, imem_req}, 32'd0);
    checkOutput("rst_pc", pc, 32'h0);
    checkOutput("rst_regwrite", {31'b0, RegWrite}, 32'd0);
    checkOutput("rst_rd", {27'b0, rd}, 32'd0);
    checkOutput("rst_rs1", {27'b0, rs1}, 32'd0);
    checkOutput("rst_rs2", {27'b0, rs2}, 32'd0);
    checkOutput("rst_imm", {20'b0, ImmOp}, 32'd0);
    checkOutput("rst_alusrc", {31'b0, ALUsrc}, 32'd0);
    checkOutput("rst_aluctrl", {31'b0, ALUctrl}, 32'd0);
    checkOutput("rst_illegal", {31'b0, illegal}, 32'd0);
    checkOutput("rst_timeout", {31'b0, imem_timeout}, 32'd0);
    rst_n = 1'b1;

    @(negedge clk);
    checkOutput("first_req", {31'b0, imem_req}, 32'd1);
    checkOutput("first_addr", imem_addr, 32'h0);

    // addi x1, x0, 5 with zero-wait ack
    applyStimulus(32'h00500093, 0, 32'h0);
    checkOutput("addi_regwrite", {31'b0, RegWrite}, 32'd1);
    checkOutput("addi_rd", {27'b0, rd}, 32'd1);
    checkOutput("addi_rs1", {27'b0, rs1}, 32'd0);
    checkOutput("addi_imm", {20'b0, ImmOp}, 32'h005);
    checkOutput("addi_alusrc", {31'b0, ALUsrc}, 32'd1);
    checkOutput("addi_aluctrl", {31'b0, ALUctrl}, 32'd0);
    checkOutput("addi_req_low", {31'b0, imem_req}, 32'd0);
    @(negedge clk);
    checkOutput("addi_next_addr", imem_addr, 32'h4);
    checkOutput("addi_next_req", {31'b0, imem_req}, 32'd1);
    checkOutput("fetch_regwrite", {31'b0, RegWrite}, 32'd0);
    checkOutput("hold_rd", {27'b0, rd}, 32'd1);
    checkOutput("hold_imm", {20'b0, ImmOp}, 32'h005);
    checkOutput("hold_alusrc", {31'b0, ALUsrc}, 32'd1);

    // addi x2, x0, 1 with the ack delayed three cycles
    applyStimulus(32'h00100113, 3, 32'h4);
    checkOutput("addi2_rd", {27'b0, rd}, 32'd2);
    checkOutput("addi2_imm", {20'b0, ImmOp}, 32'h001);
    @(negedge clk);
    checkOutput("addi2_next_addr", imem_addr, 32'h8);

    // bne x1, x0, -4 not taken when EQ=1, taken when EQ=0
    EQ = 1'b0;
    applyStimulus(32'hFE009EE3, 0, 32'h8);
    checkOutput("bne_regwrite", {31'b0, RegWrite}, 32'd0);
    checkOutput("bne_rs1", {27'b0, rs1}, 32'd1);
    checkOutput("bne_rs2", {27'b0, rs2}, 32'd0);
    checkOutput("bne_alusrc", {31'b0, ALUsrc}, 32'd0);
    checkOutput("bne_aluctrl", {31'b0, ALUctrl}, 32'd1);
    checkOutput("bne_hold_rd", {27'b0, rd}, 32'd2);
    @(negedge clk);
    checkOutput("bne_taken_addr", imem_addr, 32'h4);

    applyStimulus(32'h00100113, 0, 32'h4);
    @(negedge clk);
    checkOutput("back_to_8", imem_addr, 32'h8);

    EQ = 1'b1;
    applyStimulus(32'hFE009EE3, 0, 32'h8);
    checkOutput("bne_eq_regwrite", {31'b0, RegWrite}, 32'd0);
    @(negedge clk);
    EQ = 1'b0;
    checkOutput("bne_nottaken_addr", imem_addr, 32'hC);

    applyStimulus(32'h00100113, 0, 32'hC);
    @(negedge clk);
    checkOutput("pend_addr", imem_addr, 32'h10);
    checkOutput("pend_req", {31'b0, imem_req}, 32'd1);

    // Reset while the fetch at 0x10 is still waiting
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_req", {31'b0, imem_req}, 32'd0);
    checkOutput("midrst_addr", imem_addr, 32'h0);
    checkOutput("midrst_regwrite", {31'b0, RegWrite}, 32'd0);
    @(negedge clk);
    rst_n      = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'h00000033;
    @(negedge clk);
    imem_ack = 1'b0;
    checkOutput("stray_req", {31'b0, imem_req}, 32'd1);
    checkOutput("stray_addr", imem_addr, 32'h0);
    checkOutput("stray_regwrite", {31'b0, RegWrite}, 32'd0);
    checkOutput("stray_illegal", {31'b0, illegal}, 32'd0);

    // Illegal opcode halts until reset
    applyStimulus(32'h00000033, 0, 32'h0);
    checkOutput("illegal_exec_regwrite", {31'b0, RegWrite}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      imem_ack = (i == 2);
      @(negedge clk);
      checkOutput("halt_req", {31'b0, imem_req}, 32'd0);
      checkOutput("halt_regwrite", {31'b0, RegWrite}, 32'd0);
      checkOutput("halt_illegal", {31'b0, illegal}, 32'd1);
      checkOutput("halt_pc", pc, 32'h0);
    end
    imem_ack = 1'b0;

    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("rst2_illegal", {31'b0, illegal}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst2_req", {31'b0, imem_req}, 32'd1);

`ifdef FETCH_DECODE_TIMEOUT_EN
    // No ack: sixteen request cycles, then halt with the timeout flag
    for (int i = 0; i < 16; i++) begin
      checkOutput("to_wait_req", {31'b0, imem_req}, 32'd1);
      checkOutput("to_wait_flag", {31'b0, imem_timeout}, 32'd0);
      @(negedge clk);
    end
    checkOutput("to_req", {31'b0, imem_req}, 32'd0);
    checkOutput("to_flag", {31'b0, imem_timeout}, 32'd1);
    checkOutput("to_regwrite", {31'b0, RegWrite}, 32'd0);
    repeat (3) @(negedge clk);
    checkOutput("to_stays_halted", {31'b0, imem_req}, 32'd0);
    checkOutput("to_flag_sticky", {31'b0, imem_timeout}, 32'd1);
`else
    // No ack: the fetch simply keeps waiting
    repeat (100) @(negedge clk);
    checkOutput("nto_req", {31'b0, imem_req}, 32'd1);
    checkOutput("nto_addr", imem_addr, 32'h0);
    checkOutput("nto_flag", {31'b0, imem_timeout}, 32'd0);
    checkOutput("nto_regwrite", {31'b0, RegWrite}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_decode.md
FETCH_DECODE -- requirements
Module: fetch_decode

Interface
REQ-001 SHALL have parameters: PC_WIDTH, default 32, PC/address width; ADD_WIDTH, default 5, register address width; IMM_WIDTH, default 12, immediate width; RESET_PC, default 0, PC value after reset.
REQ-002 SHALL have one clock and an asynchronous, active-low reset.
REQ-003 SHALL have these ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- imem_req  out  1  fetch request
- imem_addr  out  PC_WIDTH  fetch address (= pc)
- imem_ack  in  1  fetch data valid
- imem_rdata  in  32  instruction word
- EQ  in  1  datapath compare result
- rs1, rs2, rd  out  ADD_WIDTH  register addresses
- RegWrite  out  1  register write enable
- ImmOp  out  IMM_WIDTH  immediate operand
- ALUsrc  out  1  1 = immediate operand
- ALUctrl  out  1  0 = add, 1 = compare
- pc  out  PC_WIDTH  current PC
- illegal  out  1  sticky illegal-opcode flag
- imem_timeout  out  1  sticky fetch-timeout flag

Function
REQ-004 SHALL implement the FSM states FETCH, EXEC and HALT.
REQ-005 FETCH: imem_req=1 and imem_addr=pc, both held stable until imem_ack is sampled high; on ack, the instruction register captures imem_rdata, the FSM goes to EXEC and imem_req drops next cycle.
REQ-006 SHALL sample imem_ack only while imem_req=1; ack in the same cycle as the first imem_req assertion SHALL be accepted (zero wait).
REQ-007 EXEC SHALL last exactly one cycle; decode outputs SHALL be driven combinationally from the instruction register.
REQ-008 addi (opcode 0010011, funct3 000): rd=IR[11:7], rs1=IR[19:15], ImmOp=IR[31:20], ALUsrc=1, ALUctrl=0, RegWrite=1 during EXEC only; next pc=pc+4.
REQ-009 bne (opcode 1100011, funct3 001): rs1=IR[19:15], rs2=IR[24:20], ALUsrc=0, ALUctrl=1, RegWrite=0; EQ sampled at the end of EXEC; EQ=0 -> pc += sign-extended {IR[31],IR[7],IR[30:25],IR[11:8],0}, else pc+4.
REQ-010 PC arithmetic SHALL wrap modulo 2^PC_WIDTH.
REQ-011 Any other opcode/funct3 in EXEC -> HALT, illegal=1, RegWrite=0, pc unchanged.
REQ-012 HALT: imem_req=0, RegWrite=0; HALT SHALL be left only by reset.
REQ-013 RegWrite SHALL be 0 in FETCH and HALT.
REQ-014 rs1/rs2/rd/ImmOp/ALUsrc/ALUctrl SHALL hold the last decoded values outside EXEC.

Reset
REQ-015 rst_n low SHALL set asynchronously: state=FETCH, pc=RESET_PC, IR=0, imem_req=0, RegWrite=0, rs1=rs2=rd=0, ImmOp=0, ALUsrc=0, ALUctrl=0, illegal=0, imem_timeout=0.
REQ-016 imem_req SHALL assert in the first cycle after rst_n rises.
REQ-017 Reset mid-fetch SHALL abandon the transaction; a late ack for it (while imem_req=0) SHALL be ignored.

Configuration
REQ-018 With macro FETCH_DECODE_TIMEOUT_EN defined: a counter SHALL run in FETCH while imem_req=1 and ack=0, and clear on ack; at TIMEOUT_CYCLES (16) consecutive cycles without ack -> HALT, imem_timeout=1.
REQ-019 Without the macro: no counter; imem_timeout SHALL be tied 0; FETCH SHALL wait indefinitely.

Structure
REQ-020 Package fetch_decode_pkg SHALL hold the opcode and funct3 constants, the FSM state enum and TIMEOUT_CYCLES.
REQ-021 Immediate extraction and sign extension SHALL be a combinational sub-module, imm_gen.

Verification
REQ-022 The bench SHALL cover these scenarios:
- Reset, zero-wait ack, rdata=0x00500093 -> one EXEC cycle with rd=1, rs1=0, ImmOp=0x005, ALUsrc=1, RegWrite=1; next imem_addr=0x4.
- pc=0x8, rdata=0xFE009EE3 (bne x1,x0,-4), EQ=0 -> next imem_addr=0x4; repeat with EQ=1 -> 0xC; RegWrite=0 in both.
- Ack delayed 3 cycles -> imem_req=1 and imem_addr constant for 4 cycles, RegWrite=0 throughout.
- rdata=0x00000033 -> HALT, illegal=1, imem_req=0 and RegWrite=0 until reset.
- rst_n low during a pending fetch at pc=0x10 -> imem_req=0 immediately; after release imem_addr=0x0; a stray ack is ignored.
- FETCH_DECODE_TIMEOUT_EN defined, no ack -> imem_timeout=1 and HALT after 16 cycles; undefined -> still in FETCH after 100 cycles.
